// File: rtl/keypad_entry_controller.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_entry_controller
//  Description : Input stage for the timer. Enables the 10-key encoder while
//                entry is allowed, debounces key press and release, and shifts
//                accepted digits into a 4-digit MM:SS entry register. A commit
//                request validates the entry and hands it to the timer as a
//                one-cycle load.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_controller #(
   parameter int DEBOUNCE_CYCLES = 4,   // consecutive stable cycles, 1..255
   parameter int NUM_DIGITS      = 4    // fixed MM:SS entry width
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        load_en,
   input  logic [3:0]  bcd,
   input  logic        valid_data,
   input  logic        commit,
   input  logic        clear_entry,
   output logic        enc_enablen,
   output logic [15:0] entry_digits,
   output logic [2:0]  digit_count,
   output logic        new_digit,
   output logic        time_load,
   output logic [15:0] time_value,
   output logic        entry_error
);

   // Key-handling states
   localparam logic [2:0] S_DISABLED   = 3'd0;
   localparam logic [2:0] S_READY      = 3'd1;
   localparam logic [2:0] S_PRESS_DB   = 3'd2;
   localparam logic [2:0] S_HELD       = 3'd3;
   localparam logic [2:0] S_RELEASE_DB = 3'd4;

   localparam logic [7:0] c_db_target  = 8'(DEBOUNCE_CYCLES);
   localparam logic [2:0] c_max_digits = 3'(NUM_DIGITS);
   localparam logic [3:0] c_max_bcd    = 4'd9;
   localparam logic [3:0] c_max_sec_tens = 4'd5;

   // Registered state
   logic [2:0]  r_state;
   logic [7:0]  r_cnt;
   logic        r_enc_enablen;
   logic [15:0] r_entry;
   logic [2:0]  r_count;
   logic        r_new_digit;
   logic        r_time_load;
   logic [15:0] r_time_value;
   logic        r_entry_error;

   // Combinational next-state signals
   logic [2:0]  w_state_nxt;
   logic [7:0]  w_cnt_nxt;
   logic        w_accept;
   logic        w_key;
   logic        w_commit;
   logic        w_has_entry;
   logic        w_entry_ok;

   // A non-decimal code from the encoder counts as "no key present"
   assign w_key       = valid_data && (bcd <= c_max_bcd);
   assign w_commit    = commit && (r_state == S_READY);
   assign w_has_entry = (r_count != 3'd0);
   assign w_entry_ok  = (r_entry[7:4] <= c_max_sec_tens);

   // Next-state, debounce counter and digit-accept decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      if (!load_en) begin
         // Losing entry permission discards any key in progress
         w_state_nxt = S_DISABLED;
         w_cnt_nxt   = 8'd0;
      end else begin
         case (r_state)
            S_DISABLED: begin
               w_state_nxt = S_READY;
               w_cnt_nxt   = 8'd0;
            end
            S_READY: begin
               if (w_key) begin
                  if (c_db_target == 8'd1) begin
                     // Single-cycle debounce: the first high sample is enough
                     w_accept    = 1'b1;
                     w_state_nxt = S_HELD;
                     w_cnt_nxt   = 8'd0;
                  end else begin
                     w_state_nxt = S_PRESS_DB;
                     w_cnt_nxt   = 8'd1;
                  end
               end
            end
            S_PRESS_DB: begin
               if (w_key) begin
                  if (r_cnt + 8'd1 == c_db_target) begin
                     w_accept    = 1'b1;
                     w_state_nxt = S_HELD;
                     w_cnt_nxt   = 8'd0;
                  end else begin
                     w_cnt_nxt   = r_cnt + 8'd1;
                  end
               end else begin
                  // Glitch shorter than the debounce window: drop it
                  w_state_nxt = S_READY;
                  w_cnt_nxt   = 8'd0;
               end
            end
            S_HELD: begin
               if (!w_key) begin
                  if (c_db_target == 8'd1) begin
                     w_state_nxt = S_READY;
                     w_cnt_nxt   = 8'd0;
                  end else begin
                     w_state_nxt = S_RELEASE_DB;
                     w_cnt_nxt   = 8'd1;
                  end
               end
            end
            S_RELEASE_DB: begin
               if (w_key) begin
                  // Bounce during release: the key is still the same press
                  w_state_nxt = S_HELD;
                  w_cnt_nxt   = 8'd0;
               end else if (r_cnt + 8'd1 == c_db_target) begin
                  w_state_nxt = S_READY;
                  w_cnt_nxt   = 8'd0;
               end else begin
                  w_cnt_nxt   = r_cnt + 8'd1;
               end
            end
            default: begin
               w_state_nxt = S_DISABLED;
               w_cnt_nxt   = 8'd0;
            end
         endcase
      end
   end

   // FSM state, debounce counter and registered encoder enable
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_DISABLED;
         r_cnt         <= 8'd0;
         r_enc_enablen <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_enc_enablen <= (w_state_nxt == S_DISABLED);
      end
   end

   // Entry register, commit handoff and status pulses; clear has top priority
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_entry       <= 16'd0;
         r_count       <= 3'd0;
         r_new_digit   <= 1'b0;
         r_time_load   <= 1'b0;
         r_time_value  <= 16'd0;
         r_entry_error <= 1'b0;
      end else begin
         r_new_digit   <= 1'b0;
         r_time_load   <= 1'b0;
         r_entry_error <= 1'b0;
         if (clear_entry) begin
            r_entry <= 16'd0;
            r_count <= 3'd0;
         end else if (w_commit && w_has_entry) begin
            if (w_entry_ok) begin
               r_time_value <= r_entry;
               r_time_load  <= 1'b1;
               r_entry      <= 16'd0;
               r_count      <= 3'd0;
            end else begin
               r_entry_error <= 1'b1;
            end
         end else if (w_accept && (r_count < c_max_digits)) begin
            // New digit enters at seconds-ones; older digits move left
            r_entry     <= {r_entry[11:0], bcd};
            r_count     <= r_count + 3'd1;
            r_new_digit <= 1'b1;
         end
      end
   end

   assign enc_enablen  = r_enc_enablen;
   assign entry_digits = r_entry;
   assign digit_count  = r_count;
   assign new_digit    = r_new_digit;
   assign time_load    = r_time_load;
   assign time_value   = r_time_value;
   assign entry_error  = r_entry_error;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_entry_controller
//  Description : Directed self-checking bench for keypad_entry_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_controller;

   logic        clock;
   logic        resetn;
   logic        load_en;
   logic [3:0]  bcd;
   logic        valid_data;
   logic        commit;
   logic        clear_entry;
   logic        enc_enablen;
   logic [15:0] entry_digits;
   logic [2:0]  digit_count;
   logic        new_digit;
   logic        time_load;
   logic [15:0] time_value;
   logic        entry_error;

   int n_vec;
   int n_err;

   keypad_entry_controller #(
      .DEBOUNCE_CYCLES(4),
      .NUM_DIGITS     (4)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .load_en     (load_en),
      .bcd         (bcd),
      .valid_data  (valid_data),
      .commit      (commit),
      .clear_entry (clear_entry),
      .enc_enablen (enc_enablen),
      .entry_digits(entry_digits),
      .digit_count (digit_count),
      .new_digit   (new_digit),
      .time_load   (time_load),
      .time_value  (time_value),
      .entry_error (entry_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance n rising edges and land 1 time unit after the last one
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Hold a key for hold_n cycles, then release for rel_n cycles; count new_digit pulses
   task automatic key(input logic [3:0] d, input int hold_n, input int rel_n, output int pulses);
      pulses = 0;
      bcd = d;
      valid_data = 1'b1;
      for (int i = 0; i < hold_n; i++) begin
         tick(1);
         if (new_digit === 1'b1) pulses++;
      end
      valid_data = 1'b0;
      for (int i = 0; i < rel_n; i++) begin
         tick(1);
         if (new_digit === 1'b1) pulses++;
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0; load_en = 1'b0; bcd = 4'd0; valid_data = 1'b0;
      commit = 1'b0; clear_entry = 1'b0;
      tick(2);
      n_vec++; if (enc_enablen !== 1'b1) begin n_err++; $display("FAIL reset_enc got %b want 1", enc_enablen); end
      n_vec++; if (entry_digits !== 16'h0000 || digit_count !== 3'd0) begin n_err++; $display("FAIL reset_entry got %h/%0d want 0000/0", entry_digits, digit_count); end
      n_vec++; if (time_value !== 16'h0000 || new_digit !== 1'b0 || time_load !== 1'b0 || entry_error !== 1'b0) begin n_err++; $display("FAIL reset_misc got tv=%h nd=%b tl=%b ee=%b want 0", time_value, new_digit, time_load, entry_error); end
      resetn = 1'b1;
      tick(1);
   endtask

   task automatic test_first_digit;
      int p;
      load_en = 1'b1;
      n_vec++; if (enc_enablen !== 1'b1) begin n_err++; $display("FAIL enable_before_edge got %b want 1", enc_enablen); end
      tick(1);
      n_vec++; if (enc_enablen !== 1'b0) begin n_err++; $display("FAIL enable_after_edge got %b want 0", enc_enablen); end
      key(4'd7, 4, 4, p);
      n_vec++; if (p !== 1) begin n_err++; $display("FAIL digit7_pulses got %0d want 1", p); end
      n_vec++; if (entry_digits !== 16'h0007 || digit_count !== 3'd1) begin n_err++; $display("FAIL digit7_entry got %h/%0d want 0007/1", entry_digits, digit_count); end
   endtask

   task automatic test_debounce;
      int p, q;
      key(4'd5, 3, 4, p);
      n_vec++; if (p !== 0 || entry_digits !== 16'h0007 || digit_count !== 3'd1) begin n_err++; $display("FAIL glitch got p=%0d %h/%0d want 0 0007/1", p, entry_digits, digit_count); end
      // Release bounce: low 1, high 1, then low long enough to finish
      key(4'd2, 4, 1, p);
      key(4'd2, 1, 4, q);
      n_vec++; if (p + q !== 1 || entry_digits !== 16'h0072 || digit_count !== 3'd2) begin n_err++; $display("FAIL bounce got p=%0d %h/%0d want 1 0072/2", p + q, entry_digits, digit_count); end
      // Non-decimal code must never be taken as a key
      key(4'd12, 6, 4, p);
      n_vec++; if (p !== 0 || entry_digits !== 16'h0072) begin n_err++; $display("FAIL bcd_gt9 got p=%0d %h want 0 0072", p, entry_digits); end
      clear_entry = 1'b1; tick(1); clear_entry = 1'b0;
      n_vec++; if (entry_digits !== 16'h0000 || digit_count !== 3'd0) begin n_err++; $display("FAIL clear got %h/%0d want 0000/0", entry_digits, digit_count); end
   endtask

   task automatic test_full_commit;
      int p;
      key(4'd1, 4, 4, p); key(4'd3, 4, 4, p); key(4'd0, 4, 4, p); key(4'd5, 4, 4, p);
      n_vec++; if (entry_digits !== 16'h1305 || digit_count !== 3'd4) begin n_err++; $display("FAIL four_digits got %h/%0d want 1305/4", entry_digits, digit_count); end
      key(4'd9, 4, 4, p);
      n_vec++; if (p !== 0 || entry_digits !== 16'h1305 || digit_count !== 3'd4) begin n_err++; $display("FAIL fifth_digit got p=%0d %h/%0d want 0 1305/4", p, entry_digits, digit_count); end
      commit = 1'b1; tick(1);
      n_vec++; if (time_load !== 1'b1 || time_value !== 16'h1305) begin n_err++; $display("FAIL commit_load got tl=%b tv=%h want 1 1305", time_load, time_value); end
      n_vec++; if (entry_digits !== 16'h0000 || digit_count !== 3'd0) begin n_err++; $display("FAIL commit_clear got %h/%0d want 0000/0", entry_digits, digit_count); end
      tick(1);
      n_vec++; if (time_load !== 1'b0 || time_value !== 16'h1305) begin n_err++; $display("FAIL commit_held got tl=%b tv=%h want 0 1305", time_load, time_value); end
      commit = 1'b0;
      tick(1);
   endtask

   task automatic test_error;
      int p;
      key(4'd1, 4, 4, p); key(4'd7, 4, 4, p); key(4'd0, 4, 4, p);
      commit = 1'b1; tick(1); commit = 1'b0;
      n_vec++; if (entry_error !== 1'b1 || time_load !== 1'b0) begin n_err++; $display("FAIL bad_commit got ee=%b tl=%b want 1 0", entry_error, time_load); end
      n_vec++; if (entry_digits !== 16'h0170 || digit_count !== 3'd3) begin n_err++; $display("FAIL bad_commit_entry got %h/%0d want 0170/3", entry_digits, digit_count); end
      tick(1);
      n_vec++; if (entry_error !== 1'b0) begin n_err++; $display("FAIL error_width got %b want 0", entry_error); end
      clear_entry = 1'b1; tick(1); clear_entry = 1'b0;
   endtask

   task automatic test_commit_clear_held;
      int p;
      key(4'd4, 4, 4, p); key(4'd2, 4, 4, p);
      n_vec++; if (entry_digits !== 16'h0042) begin n_err++; $display("FAIL entry42 got %h want 0042", entry_digits); end
      commit = 1'b1; clear_entry = 1'b1; tick(1); commit = 1'b0; clear_entry = 1'b0;
      n_vec++; if (entry_digits !== 16'h0000 || time_load !== 1'b0 || entry_error !== 1'b0 || time_value !== 16'h1305) begin n_err++; $display("FAIL commit_and_clear got %h tl=%b ee=%b tv=%h want 0000 0 0 1305", entry_digits, time_load, entry_error, time_value); end
      // Commit while the key is still held must be ignored
      bcd = 4'd4; valid_data = 1'b1; tick(4);
      commit = 1'b1; tick(1); commit = 1'b0;
      n_vec++; if (time_load !== 1'b0 || entry_digits !== 16'h0004 || digit_count !== 3'd1) begin n_err++; $display("FAIL commit_in_held got tl=%b %h/%0d want 0 0004/1", time_load, entry_digits, digit_count); end
      valid_data = 1'b0; tick(4);
   endtask

   task automatic test_disable_reset;
      int p;
      bcd = 4'd8; valid_data = 1'b1; tick(2);
      load_en = 1'b0; tick(1);
      n_vec++; if (enc_enablen !== 1'b1) begin n_err++; $display("FAIL disable_enc got %b want 1", enc_enablen); end
      tick(3);
      valid_data = 1'b0; load_en = 1'b1; tick(1);
      n_vec++; if (enc_enablen !== 1'b0 || entry_digits !== 16'h0004 || digit_count !== 3'd1) begin n_err++; $display("FAIL disable_retain got en=%b %h/%0d want 0 0004/1", enc_enablen, entry_digits, digit_count); end
      key(4'd6, 4, 0, p);
      n_vec++; if (p !== 1 || entry_digits !== 16'h0046) begin n_err++; $display("FAIL pre_reset_digit got p=%0d %h want 1 0046", p, entry_digits); end
      valid_data = 1'b1; tick(2);
      #2 resetn = 1'b0;
      #1;
      n_vec++; if (enc_enablen !== 1'b1 || entry_digits !== 16'h0000 || digit_count !== 3'd0 || time_value !== 16'h0000) begin n_err++; $display("FAIL async_reset got en=%b %h/%0d tv=%h want 1 0000/0 0000", enc_enablen, entry_digits, digit_count, time_value); end
      valid_data = 1'b0;
      tick(1);
      resetn = 1'b1;
      tick(1);
      n_vec++; if (enc_enablen !== 1'b0) begin n_err++; $display("FAIL reenable got %b want 0", enc_enablen); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset;
      test_first_digit;
      test_debounce;
      test_full_commit;
      test_error;
      test_commit_clear_held;
      test_disable_reset;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
